// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus a DEPTH-entry prefetch queue of {instr, pc, tag}.
// Fetches from a 1-cycle-latency instruction memory and hands instructions to
// decode over a valid/ready handshake. A redirect flushes the queue and any
// in-flight fetch, reloads the PC and advances the tag.
module fetch_queue #(
  parameter logic [31:0] START_ADDRESS = 32'h0000_0000,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TAG_W         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             i_req,
  output logic [31:0]      i_address,
  input  logic [31:0]      i_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0]      pc_q, pc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];

  logic             issue;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic [CNT_W:0]   credits_used;
  entry_t           head_entry;

  // Pointer advance that wraps at DEPTH, so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check: every queued entry and the one outstanding fetch hold a slot,
  // so a response always finds room and the queue can never overflow.
  assign credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

  // NOTE: the request is also masked by the asynchronous reset input itself, so
  // imem sees no fetch while reset is held even though the queue looks empty.
  assign issue     = reset && !redirect && (credits_used < {1'b0, DEPTH_CNT});
  assign not_empty = (count_q != '0);
  assign push      = inflight_q && !redirect;
  assign pop       = out_valid && out_ready;

  assign i_req      = issue;
  assign i_address  = pc_q;
  assign head_entry = mem_q[head_q];
  assign out_valid  = not_empty && !redirect;
  assign out_instr  = not_empty ? head_entry.instr : '0;
  assign out_pc     = not_empty ? head_entry.pc    : '0;
  assign out_tag    = not_empty ? head_entry.tag   : '0;

  // Next-state logic for PC, tag, in-flight tracking and queue pointers.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    pc_d          = pc_q;
    tag_d         = tag_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (redirect) begin
      // Redirect wins over everything: drop the queue and the response arriving now.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      tag_d      = tag_q + TAG_W'(1);
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      pc_q          <= START_ADDRESS;
      tag_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      tag_q         <= tag_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Queue storage write at the tail when the fetch response arrives.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; outputs are forced to
    // zero whenever the queue is empty, so stale contents are never visible.
    if (push) begin
      mem_q[tail_q] <= '{instr: i_rdata, pc: inflight_pc_q, tag: tag_q};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: three instances (DEPTH 4, 2, 8) share stimulus; each
// has a queue-based reference model and a per-cycle compare process. Directed
// checks on the DEPTH=4 instance pin the model with hand-computed values.
module tb_fetch_queue;

  localparam int N = 3;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  tag;
  } ent_t;

  logic        clk         = 1'b0;
  logic        reset       = 1'b0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready   = 1'b0;
  logic [31:0] data_xor    = '0;

  int total = 0;
  int bad   = 0;

  logic        o_req   [N];
  logic [31:0] o_addr  [N];
  logic        o_valid [N];
  logic [31:0] o_instr [N];
  logic [31:0] o_pc    [N];
  logic [3:0]  o_tag   [N];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int          D = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    localparam logic [31:0] S = (g == 0) ? 32'h0000_0000 :
                                ((g == 1) ? 32'hFFFF_FFF0 : 32'h0000_1000);

    logic [31:0] rdata_r = '0;

    fetch_queue #(
      .START_ADDRESS(S),
      .DEPTH        (D),
      .TAG_W        (4)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .i_req      (o_req[g]),
      .i_address  (o_addr[g]),
      .i_rdata    (rdata_r),
      .out_valid  (o_valid[g]),
      .out_ready  (out_ready),
      .out_instr  (o_instr[g]),
      .out_pc     (o_pc[g]),
      .out_tag    (o_tag[g])
    );

    // Instruction memory: data = address ^ data_xor one cycle after a request,
    // junk otherwise so a spurious push is visible.
    always @(posedge clk) rdata_r <= o_req[g] ? (o_addr[g] ^ data_xor) : $urandom;

    // Reference model and compare process.
    initial begin
      ent_t        q[$];
      logic [31:0] m_pc;
      logic [3:0]  m_tag;
      bit          m_pend;
      logic [31:0] m_pend_pc;
      bit          e_req;
      bit          e_valid;
      int          n;
      string       p;
      m_pc      = S;
      m_tag     = '0;
      m_pend    = 1'b0;
      m_pend_pc = '0;
      p = $sformatf("d%0d", D);
      forever begin
        @(negedge clk);
        #2;
        if (!reset) begin
          q.delete();
          m_pc   = S;
          m_tag  = '0;
          m_pend = 1'b0;
        end
        n       = q.size();
        e_req   = reset && !redirect && ((n + int'(m_pend)) < D);
        e_valid = reset && !redirect && (n > 0);
        check({p, "_req"},   32'(o_req[g]),   32'(e_req));
        check({p, "_addr"},  o_addr[g],       m_pc);
        check({p, "_valid"}, 32'(o_valid[g]), 32'(e_valid));
        if (n == 0) begin
          check({p, "_instr0"}, o_instr[g], '0);
          check({p, "_pc0"},    o_pc[g],    '0);
          check({p, "_tag0"},   32'(o_tag[g]), '0);
        end else if (e_valid) begin
          check({p, "_instr"}, o_instr[g],    q[0].instr);
          check({p, "_pc"},    o_pc[g],       q[0].pc);
          check({p, "_tag"},   32'(o_tag[g]), 32'(q[0].tag));
        end
        @(posedge clk);
        if (reset) begin
          if (redirect) begin
            q.delete();
            m_pend = 1'b0;
            m_pc   = {redirect_pc[31:2], 2'b00};
            m_tag  = m_tag + 4'd1;
          end else begin
            if (n > 0 && out_ready) void'(q.pop_front());
            if (m_pend) q.push_back('{instr: m_pend_pc ^ data_xor, pc: m_pend_pc, tag: m_tag});
            m_pend    = e_req;
            m_pend_pc = m_pc;
            if (e_req) m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // One redirect burst followed by the first new instruction at R+3.
  task automatic redir(input logic [31:0] tgt, input int cnt, input logic [3:0] etag,
                       input string nm);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = tgt;
      #3;
      check({nm, "_req_r"},   32'(o_req[0]),   0);
      check({nm, "_valid_r"}, 32'(o_valid[0]), 0);
    end
    @(negedge clk);
    redirect = 1'b0;
    #3;
    check({nm, "_req1"},   32'(o_req[0]),   1);
    check({nm, "_addr1"},  o_addr[0],       tgt & 32'hFFFF_FFFC);
    check({nm, "_valid1"}, 32'(o_valid[0]), 0);
    @(negedge clk);
    #3;
    check({nm, "_valid2"}, 32'(o_valid[0]), 0);
    @(negedge clk);
    #3;
    check({nm, "_valid3"}, 32'(o_valid[0]), 1);
    check({nm, "_pc3"},    o_pc[0],         tgt & 32'hFFFF_FFFC);
    check({nm, "_instr3"}, o_instr[0],      tgt & 32'hFFFF_FFFC);
    check({nm, "_tag3"},   32'(o_tag[0]),   32'(etag));
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int ready_pct;
    reset       = 1'b0;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    data_xor    = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_req",   32'(o_req[0]),   0);
    check("rst_addr",  o_addr[0],       0);
    check("rst_addr2", o_addr[1],       32'hFFFF_FFF0);
    check("rst_valid", 32'(o_valid[0]), 0);
    check("rst_pc",    o_pc[0],         0);
    check("rst_tag",   32'(o_tag[0]),   0);

    // Reset release and steady streaming.
    @(negedge clk);
    reset = 1'b1;
    #3;
    check("t1_req0",   32'(o_req[0]),   1);
    check("t1_addr0",  o_addr[0],       0);
    check("t1_valid0", 32'(o_valid[0]), 0);
    @(negedge clk);
    #3;
    check("t1_valid1", 32'(o_valid[0]), 0);
    check("t1_addr1",  o_addr[0],       4);
    for (int c = 2; c < 8; c++) begin
      @(negedge clk);
      #3;
      check($sformatf("t1_valid%0d", c), 32'(o_valid[0]), 1);
      check($sformatf("t1_pc%0d", c),    o_pc[0],         (c - 2) * 4);
      check($sformatf("t1_instr%0d", c), o_instr[0],      (c - 2) * 4);
      check($sformatf("t1_tag%0d", c),   32'(o_tag[0]),   0);
    end

    // Back-pressure: queue fills to DEPTH and fetch stops.
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 11; c < 13; c++) begin
      @(negedge clk);
      #3;
      check($sformatf("t2_req%0d", c),   32'(o_req[0]),   0);
      check($sformatf("t2_addr%0d", c),  o_addr[0],       40);
      check($sformatf("t2_valid%0d", c), 32'(o_valid[0]), 1);
      check($sformatf("t2_pc%0d", c),    o_pc[0],         24);
    end
    for (int c = 13; c < 18; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #3;
      check($sformatf("t2_pc%0d", c),  o_pc[0],       24 + 4 * (c - 13));
      check($sformatf("t2_req%0d", c), 32'(o_req[0]), (c == 13) ? 0 : 1);
      if (c > 13) check($sformatf("t2_addr%0d", c), o_addr[0], 40 + 4 * (c - 14));
    end

    // Redirects: single, then tag wrap through 15 to 0.
    redir(32'h0000_0103, 1,  4'd1,  "t3");
    redir(32'h0000_0202, 14, 4'd15, "t4a");
    redir(32'h0000_0301, 1,  4'd0,  "t4b");

    // Reset while the queue is full.
    @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("t5_full_req",   32'(o_req[0]),   0);
    check("t5_full_valid", 32'(o_valid[0]), 1);
    check("t5_full_pc",    o_pc[0],         32'h304);
    @(negedge clk);
    reset = 1'b0;
    #3;
    check("t5_rst_req",   32'(o_req[0]),   0);
    check("t5_rst_valid", 32'(o_valid[0]), 0);
    check("t5_rst_addr",  o_addr[0],       0);
    check("t5_rst_pc",    o_pc[0],         0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    #3;
    check("t5_req0",  32'(o_req[0]), 1);
    check("t5_addr0", o_addr[0],     0);
    repeat (2) @(negedge clk);
    #3;
    check("t5_valid2", 32'(o_valid[0]), 1);
    check("t5_pc2",    o_pc[0],         0);
    check("t5_tag2",   32'(o_tag[0]),   0);

    // Randomized traffic on all depths.
    @(negedge clk);
    reset    = 1'b0;
    data_xor = $urandom;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      case ((i / 500) % 4)
        0:       ready_pct = 100;
        1:       ready_pct = 50;
        2:       ready_pct = 10;
        default: ready_pct = 90;
      endcase
      out_ready = ($urandom_range(0, 99) < ready_pct);
      redirect  = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      if (i % 1000 == 999) begin
        reset    = 1'b0;
        data_xor = $urandom;
      end else begin
        reset = 1'b1;
      end
    end
    @(negedge clk);
    redirect  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
